proc_hier_top: RTL and testbench
================================

Name: proc_hier_top

Overview:
Top of the processor hierarchy. Owns clock/reset conditioning, instantiates the existing pipelined core `proc` (instance p0), and exposes a flat commit-trace/observation bus and performance counters. The simulation bench uses these to produce the register/memory trace and the cycle and instruction statistics. No caches exist in this configuration; cache request and hit outputs are constant 0.

Parameters:
DATA_W, 16, datapath/PC/memory word width
REG_AW, 3, register-select width (8 GPRs)
CNT_W, 32, width of every performance counter

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
pc  out  DATA_W  core IF-stage PC
inst  out  DATA_W  core fetched-instruction register
reg_write  out  1  register file write enable this cycle
write_register  out  REG_AW  destination register being written
write_data  out  DATA_W  data being written to the register file
mem_read  out  1  data memory read this cycle
mem_write  out  1  data memory write this cycle
mem_address  out  DATA_W  data memory address (read and write)
mem_data_in  out  DATA_W  store data presented to data memory
mem_data_out  out  DATA_W  load data returned by data memory
halt  out  1  core halt (HALT in MEM/WB)
halted  out  1  sticky halt flag
core_rst  out  1  active-high reset as seen by the core
cycle_count  out  CNT_W  cycles since reset release
inst_count  out  CNT_W  retired-event count
icache_req, icache_hit, dcache_req, dcache_hit  out  1 each  tied 0

Behaviour:
- Reset: rst_n low asserts core_rst immediately (async). Release goes through a 2-flop synchronizer, so core_rst falls on the 2nd posedge after rst_n rises. Core p0 receives clk and core_rst.
- While core_rst=1: cycle_count=0, inst_count=0, halted=0. All trace outputs follow the core, which holds reset state, so reg_write=mem_read=mem_write=halt=0.
- Trace bus is purely combinational from core internals, with no added latency:
  - reg_write, write_register, write_data = rf write port.
  - mem_read = dmem enable & ~wr; mem_write = dmem enable & wr; never both 1.
  - mem_address, mem_data_in, mem_data_out = dmem addr, data_in, data_out.
- Counters are registered and update on posedge only when core_rst=0 and halted=0:
  - cycle_count += 1 every such cycle.
  - inst_count += 1 when (halt | reg_write | mem_write).
- halted is set on the posedge where halt=1 and core_rst=0. It stays set until reset, and freezes both counters afterwards. The halt cycle itself is counted in both counters.
- Counter overflow wraps modulo 2^CNT_W.
- Reset asserted mid-run: core_rst rises at once and all counters and halted clear asynchronously.
- Cache outputs are constant 0 at all times.

Decomposition:
- Shared package proc_pkg: DATA_W, REG_AW, CNT_W, and the 16-bit word typedef.
- Sub-module rst_sync: 2-flop async-assert, sync-release synchronizer, active-low in, active-high out.
- Core `proc` and its rf and data_mem are existing blocks; counters live in this module.

Test Plan:
- Reset release: rst_n 0→1 with clk running → core_rst falls on 2nd posedge; cycle_count=1 one posedge later; inst_count=0.
- Async reset: drop rst_n between edges after 50 cycles → core_rst=1 and cycle_count=0 immediately, with no clock edge.
- Register write: program `lbi r1,0x12` → one cycle with reg_write=1, write_register=1, write_data=0x0012; inst_count increments by 1.
- Store/load: st r1→[0x0004], then ld from [0x0004] → store cycle: mem_write=1, mem_read=0, mem_address=0x0004, mem_data_in=0x0012. Load cycle: mem_read=1, mem_data_out=0x0012. inst_count counts the store and the load's register write.
- Halt: 3-instruction program ending in HALT → halted=1 after the halt edge. cycle_count and inst_count (=3) stay frozen for 20 further cycles.
- Cache stubs: over the whole run, icache_req, icache_hit, dcache_req and dcache_hit are never 1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared widths, opcodes and the boot program ROM for the proc hierarchy.
package proc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned CNT_W  = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpHalt = 4'h1,
        OpLbi  = 4'h2,
        OpSt   = 4'h3,
        OpLd   = 4'h4,
        OpAdd  = 4'h5
    } opcode_e;

    // Encoding: [15:12] op, [11:9] rd/rs_store, [8:6] rs, [5:3] rt, [7:0] imm8
    function automatic word_t imem_word(input logic [3:0] addr);
        word_t w;
        case (addr)
            4'd0:    w = 16'h2212; // lbi r1, 0x12
            4'd1:    w = 16'h3204; // st  r1, [0x04]
            4'd2:    w = 16'h4404; // ld  r2, [0x04]
            4'd3:    w = 16'h5650; // add r3, r1, r2
            4'd4:    w = 16'h2880; // lbi r4, 0x80 (sign-extended)
            4'd5:    w = 16'h0000; // nop
            default: w = 16'h1000; // halt
        endcase
        return w;
    endfunction

endpackage

// File: rtl/proc.sv
// Two-stage core: fetch register, then a combined execute/memory/writeback stage.
module proc
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              dmem_en,
    output logic              dmem_wr,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_data_in,
    output logic [DATA_W-1:0] dmem_data_out,
    output logic              halt
);

    word_t             pc_q, pc_d, inst_q, inst_d;
    word_t             imm_s, imm_z, rdata_a, rdata_b;
    logic [REG_AW-1:0] raddr_a, raddr_b;
    opcode_e           op;

    assign op      = opcode_e'(inst_q[15:12]);
    assign imm_s   = {{8{inst_q[7]}}, inst_q[7:0]};
    assign imm_z   = {8'h00, inst_q[7:0]};
    // Stores name their source register in the rd field.
    assign raddr_a = (op == OpSt) ? inst_q[11:9] : inst_q[8:6];
    assign raddr_b = inst_q[5:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    always_comb begin
        rf_we     = 1'b0;
        rf_wdata  = '0;
        dmem_en   = 1'b0;
        dmem_wr   = 1'b0;
        halt      = 1'b0;
        unique case (op)
            OpHalt: halt = 1'b1;
            OpLbi: begin
                rf_we    = 1'b1;
                rf_wdata = imm_s;
            end
            OpSt: begin
                dmem_en = 1'b1;
                dmem_wr = 1'b1;
            end
            OpLd: begin
                dmem_en  = 1'b1;
                rf_we    = 1'b1;
                rf_wdata = dmem_data_out;
            end
            OpAdd: begin
                rf_we    = 1'b1;
                rf_wdata = rdata_a + rdata_b;
            end
            default: ;
        endcase
    end

    // A halt holds fetch so HALT stays in the back stage until reset.
    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        if (!halt) begin
            pc_d   = pc_q + DATA_W'(1);
            inst_d = imem_word(pc_q[3:0]);
        end
    end

    assign pc           = pc_q;
    assign inst         = inst_q;
    assign rf_waddr     = inst_q[11:9];
    assign dmem_addr    = imm_z;
    assign dmem_data_in = rdata_a;

    rf u_rf (
        .clk     (clk),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    data_mem u_data_mem (
        .clk      (clk),
        .en       (dmem_en),
        .wr       (dmem_wr),
        .addr     (dmem_addr),
        .data_in  (dmem_data_in),
        .data_out (dmem_data_out)
    );

endmodule

// File: rtl/proc_data_mem.sv
// Small data memory: synchronous write, combinational read, word addressed.
module data_mem
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              wr,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned Depth = 16;

    word_t mem_q [Depth];
    logic  unused_addr;

    // Only the low address bits select a word; the rest alias.
    assign unused_addr = ^addr[DATA_W-1:4];

    always_ff @(posedge clk) begin
        if (en && wr) begin
            mem_q[addr[3:0]] <= data_in;
        end
    end

    assign data_out = mem_q[addr[3:0]];

endmodule

// File: rtl/proc_rf.sv
// Eight-entry register file: two combinational read ports, one synchronous write port.
module rf
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    word_t regs_q [2**REG_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/proc_rst_sync.sv
// Reset synchronizer: asynchronous assert, release after two clock edges.
module rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst = ~sync_q[1];

endmodule

// File: rtl/proc_hier_top.sv
// Processor hierarchy top: reset conditioning, core p0, flat trace bus and perf counters.
module proc_hier_top
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              reg_write,
    output logic [REG_AW-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              halt,
    output logic              halted,
    output logic              core_rst,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic              icache_req,
    output logic              icache_hit,
    output logic              dcache_req,
    output logic              dcache_hit
);

    logic             dmem_en, dmem_wr;
    logic [CNT_W-1:0] cycle_q, cycle_d, inst_cnt_q, inst_cnt_d;
    logic             halted_q, halted_d;

    rst_sync u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rst   (core_rst)
    );

    proc p0 (
        .clk           (clk),
        .rst           (core_rst),
        .pc            (pc),
        .inst          (inst),
        .rf_we         (reg_write),
        .rf_waddr      (write_register),
        .rf_wdata      (write_data),
        .dmem_en       (dmem_en),
        .dmem_wr       (dmem_wr),
        .dmem_addr     (mem_address),
        .dmem_data_in  (mem_data_in),
        .dmem_data_out (mem_data_out),
        .halt          (halt)
    );

    assign mem_read  = dmem_en & ~dmem_wr;
    assign mem_write = dmem_en & dmem_wr;

    // core_rst asserts asynchronously with rst_n, so mid-run resets clear the counters at once.
    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            cycle_q    <= '0;
            inst_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            inst_cnt_q <= inst_cnt_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        cycle_d    = cycle_q;
        inst_cnt_d = inst_cnt_q;
        halted_d   = halted_q;
        if (!halted_q) begin
            cycle_d = cycle_q + CNT_W'(1);
            if (halt || reg_write || mem_write) begin
                inst_cnt_d = inst_cnt_q + CNT_W'(1);
            end
            if (halt) begin
                halted_d = 1'b1;
            end
        end
    end

    assign cycle_count = cycle_q;
    assign inst_count  = inst_cnt_q;
    assign halted      = halted_q;

    assign icache_req = 1'b0;
    assign icache_hit = 1'b0;
    assign dcache_req = 1'b0;
    assign dcache_hit = 1'b0;

endmodule

// File: tb/tb_proc_hier_top.sv
// Bench for proc_hier_top: reset sequencing, trace bus scoreboard, halt freeze, async reset.
module tb_proc_hier_top;
    import proc_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] pc, inst, write_data, mem_address, mem_data_in, mem_data_out;
    logic [REG_AW-1:0] write_register;
    logic              reg_write, mem_read, mem_write, halt, halted, core_rst;
    logic [CNT_W-1:0]  cycle_count, inst_count;
    logic              icache_req, icache_hit, dcache_req, dcache_hit;

    proc_hier_top dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .inst           (inst),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .halt           (halt),
        .halted         (halted),
        .core_rst       (core_rst),
        .cycle_count    (cycle_count),
        .inst_count     (inst_count),
        .icache_req     (icache_req),
        .icache_hit     (icache_hit),
        .dcache_req     (dcache_req),
        .dcache_hit     (dcache_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        mr;
        logic        mw;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] dout;
        logic        hlt;
        logic        hltd;
        logic [31:0] cyc;
        logic [31:0] icnt;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] prog   [8];
    logic [15:0] m_regs [8];
    logic [15:0] m_mem  [16];
    logic        cache_seen = 1'b0;
    logic        both_seen  = 1'b0;

    always @(negedge clk) begin
        if (icache_req || icache_hit || dcache_req || dcache_hit) cache_seen <= 1'b1;
        if (mem_read && mem_write) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference ISA model: one record per cycle, starting with the NOP held at reset.
    task automatic build_expectations(input int n);
        logic [15:0] pc_m, ir;
        logic [31:0] cyc, ic;
        logic        hd;
        exp_t        e;
        pc_m = '0; ir = '0; cyc = '0; ic = '0; hd = 1'b0;
        for (int i = 0; i < n; i++) begin
            e      = '0;
            e.cyc  = cyc;
            e.icnt = ic;
            e.hltd = hd;
            case (ir[15:12])
                4'h1: e.hlt = 1'b1;
                4'h2: begin
                    e.rw = 1'b1; e.wreg = ir[11:9]; e.wdata = {{8{ir[7]}}, ir[7:0]};
                end
                4'h3: begin
                    e.mw = 1'b1; e.addr = {8'h00, ir[7:0]}; e.din = m_regs[ir[11:9]];
                end
                4'h4: begin
                    e.mr = 1'b1; e.addr = {8'h00, ir[7:0]}; e.dout = m_mem[ir[3:0]];
                    e.rw = 1'b1; e.wreg = ir[11:9]; e.wdata = e.dout;
                end
                4'h5: begin
                    e.rw = 1'b1; e.wreg = ir[11:9]; e.wdata = m_regs[ir[8:6]] + m_regs[ir[5:3]];
                end
                default: ;
            endcase
            sb_q.push_back(e);
            if (!hd) begin
                cyc++;
                if (e.hlt || e.rw || e.mw) ic++;
                if (e.hlt) hd = 1'b1;
            end
            if (e.rw) m_regs[e.wreg] = e.wdata;
            if (e.mw) m_mem[e.addr[3:0]] = e.din;
            if (!e.hlt) begin
                ir   = prog[pc_m[2:0]];
                pc_m = pc_m + 16'd1;
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("core_rst_after_edge1", core_rst, 1);
        check("reg_write_in_reset", reg_write, 0);
        @(posedge clk); #1;
        check("core_rst_after_edge2", core_rst, 0);
        check("cycle_at_release", cycle_count, 0);
    endtask

    task automatic run_program(input int n);
        exp_t e;
        build_expectations(n);
        for (int i = 0; i < n; i++) begin
            e = sb_q.pop_front();
            check("reg_write", reg_write, e.rw);
            if (e.rw) begin
                check("write_register", write_register, e.wreg);
                check("write_data", write_data, e.wdata);
            end
            check("mem_read", mem_read, e.mr);
            check("mem_write", mem_write, e.mw);
            if (e.mr || e.mw) check("mem_address", mem_address, e.addr);
            if (e.mw) check("mem_data_in", mem_data_in, e.din);
            if (e.mr) check("mem_data_out", mem_data_out, e.dout);
            check("halt", halt, e.hlt);
            check("halted", halted, e.hltd);
            check("cycle_count", cycle_count, e.cyc);
            check("inst_count", inst_count, e.icnt);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        prog[0] = 16'h2212; prog[1] = 16'h3204; prog[2] = 16'h4404; prog[3] = 16'h5650;
        prog[4] = 16'h2880; prog[5] = 16'h0000; prog[6] = 16'h1000; prog[7] = 16'h1000;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst", core_rst, 1);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_inst_count", inst_count, 0);
        check("rst_halted", halted, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_halt", halt, 0);

        release_reset();
        run_program(12);

        repeat (20) @(posedge clk);
        #1;
        check("frozen_cycle_count", cycle_count, 8);
        check("frozen_inst_count", inst_count, 6);
        check("frozen_halted", halted, 1);

        // Drop reset between edges; counters must clear without a clock edge.
        repeat (16) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_core_rst", core_rst, 1);
        check("async_cycle_count", cycle_count, 0);
        check("async_inst_count", inst_count, 0);
        check("async_halted", halted, 0);

        release_reset();
        run_program(12);

        check("cache_outputs_seen", cache_seen, 0);
        check("mem_read_write_both", both_seen, 0);
        check("scoreboard_left", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
